ram_byte_master: RTL and testbench

//   Initiator side of the byte-wide synchronous-read single-port RAM. Serialises 32-bit

---
 rtl/ram_master_pkg.sv | 29 ++
 rtl/ram_byte_master.sv | 168 ++++++++++++++++
 tb/tb_ram_byte_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_master_pkg.sv
// rtl/ram_master_pkg.sv - shared encodings for the byte-wide RAM initiator
package ram_master_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_e;

    // Encoding 3 is illegal and is treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_byte_master.sv
// rtl/ram_byte_master.sv - serialises 32-bit fetch/load/store requests into byte RAM cycles
module ram_byte_master
    import ram_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  if_valid,
    input  logic [31:0]           if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_valid,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    state_e                state_q, state_d;
    src_e                  src_q, src_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            len_q, len_d;
    logic [2:0]            step_q, step_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           asm_q, asm_d;
    logic                  if_done_q, if_done_d;
    logic                  ls_done_q, ls_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_wdata_q, ram_wdata_d;

    logic                  accept;
    logic [31:0]           req_addr;
    logic [ADDR_WIDTH-1:0] step_addr;
    logic [1:0]            cap_lane;
    logic [31:0]           asm_merged;
    logic                  unused_addr_hi;

    // step_q names the edge about to happen: E1 is the first edge after the accept.
    assign accept     = !clear && (ls_valid || if_valid);
    assign req_addr   = ls_valid ? ls_addr : if_addr;
    assign step_addr  = base_q + ADDR_WIDTH'(step_q);
    assign cap_lane   = step_q[1:0] - 2'd2;
    assign unused_addr_hi = ^{if_addr[31:ADDR_WIDTH], ls_addr[31:ADDR_WIDTH]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            base_q      <= '0;
            len_q       <= '0;
            step_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_data_q   <= '0;
            ls_rdata_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            base_q      <= base_d;
            len_q       <= len_d;
            step_q      <= step_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (ls_valid && ls_wr) ? WRITE : READ;
            READ:    if (clear) state_d = IDLE;
                     else if (step_q == len_q + 3'd1) state_d = DONE;
            WRITE:   if (step_q == len_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_d       = src_q;
        base_d      = base_q;
        len_d       = len_q;
        step_d      = step_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        if_data_d   = if_data_q;
        ls_rdata_d  = ls_rdata_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        asm_merged  = asm_q;
        asm_merged[{cap_lane, 3'b000} +: 8] = ram_rdata;
        case (state_q)
            IDLE: if (accept) begin
                src_d       = ls_valid ? SRC_LS : SRC_IF;
                base_d      = req_addr[ADDR_WIDTH-1:0];
                len_d       = ls_valid ? size_bytes(ls_size) : 3'd4;
                wdata_d     = ls_wdata;
                asm_d       = '0;
                step_d      = 3'd1;
                ram_addr_d  = req_addr[ADDR_WIDTH-1:0];
                ram_we_d    = ls_valid && ls_wr;
                ram_wdata_d = ls_wdata[7:0];
            end
            // Read bytes land one edge after their address edge, so capture lags issue by two.
            READ: if (!clear) begin
                if (step_q < len_q) ram_addr_d = step_addr;
                if (step_q >= 3'd2) asm_d = asm_merged;
                if (step_q == len_q + 3'd1) begin
                    if (src_q == SRC_LS) begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = asm_merged;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = asm_merged;
                    end
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            WRITE: begin
                if (step_q == len_q) begin
                    ram_we_d  = 1'b0;
                    ls_done_d = 1'b1;
                end else begin
                    ram_addr_d  = step_addr;
                    ram_wdata_d = wdata_q[{step_q[1:0], 3'b000} +: 8];
                    step_d      = step_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign ls_done   = ls_done_q;
    assign ls_rdata  = ls_rdata_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_byte_master.sv
// tb/tb_ram_byte_master.sv - directed and randomized checks of ram_byte_master against a byte-array model
module tb_ram_byte_master;
    import ram_master_pkg::*;

    localparam int AW  = 17;
    localparam int MEM = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n, clear;
    logic          if_valid, ls_valid, ls_wr;
    logic [31:0]   if_addr, ls_addr, ls_wdata;
    logic [1:0]    ls_size;
    logic          if_done, ls_done, ram_we;
    logic [31:0]   if_data, ls_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, ram_rdata;

    logic [7:0]    mem     [0:MEM-1];
    logic [7:0]    ref_mem [0:MEM-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_data;

    int checks = 0;
    int errors = 0;
    int we_cnt, ifd_cnt, lsd_cnt;

    always #5 clk = ~clk;

    ram_byte_master #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous-read RAM with a backdoor write port for preloading.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (ram_we)  we_cnt++;
        if (if_done) ifd_cnt++;
        if (ls_done) lsd_cnt++;
    endtask

    task automatic clr_cnt();
        we_cnt = 0; ifd_cnt = 0; lsd_cnt = 0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        ref_mem[a] = d;
        step();
        bd_we = 1'b0;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ref_mem[AW'(a + i)];
        return r;
    endfunction

    task automatic apply_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) ref_mem[AW'(a + i)] = wd[8*i +: 8];
    endtask

    task automatic chk_mem(input string tag, input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) chk(tag, {24'h0, mem[AW'(a + i)]}, {24'h0, ref_mem[AW'(a + i)]});
    endtask

    // Issues one request and waits (bounded) for its done pulse plus the following IDLE cycle.
    task automatic req(input bit ls, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int clr_at,
                       output logic [31:0] data, output int lat);
        clr_cnt();
        lat  = 0;
        data = '0;
        if (ls) begin
            ls_valid = 1'b1; ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd;
        end else begin
            if_valid = 1'b1; if_addr = a;
        end
        for (int k = 1; k <= 30; k++) begin
            step();
            if (clear) clear = 1'b0;
            if (ls ? ls_done : if_done) begin
                lat  = k;
                data = ls ? ls_rdata : if_data;
                break;
            end
            if (k == clr_at) begin
                clear = 1'b1;
                if (!wr) begin if_valid = 1'b0; ls_valid = 1'b0; end
            end
        end
        if_valid = 1'b0;
        ls_valid = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] d, e, a, wd;
        logic [1:0]  sz;
        int          lat, n, op, k_ls, k_if;
        logic [31:0] d_ls, d_if;

        rst_n = 1'b0; clear = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        if_valid = 1'b0; if_addr = '0; ls_valid = 1'b0; ls_wr = 1'b0;
        ls_size = '0; ls_addr = '0; ls_wdata = '0;
        clr_cnt();
        @(negedge clk);
        step(); step();
        chk("rst_if_done", {31'h0, if_done}, 32'h0);
        chk("rst_ls_done", {31'h0, ls_done}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_wdata", {24'h0, ram_wdata}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst_n = 1'b1;
        step();

        // Word fetch from preloaded bytes
        poke(17'h10, 8'h11); poke(17'h11, 8'h22); poke(17'h12, 8'h33); poke(17'h13, 8'h44);
        req(1'b0, 1'b0, SIZE_W, 32'h10, '0, 0, d, lat);
        chk("fetch_data", d, 32'h44332211);
        chk("fetch_lat", lat, 6);
        chk("fetch_done_cnt", ifd_cnt, 1);
        chk("fetch_we_cnt", we_cnt, 0);

        // Half store then byte load
        req(1'b1, 1'b1, SIZE_H, 32'h3, 32'h1234BEEF, 0, d, lat);
        apply_store(32'h3, 2, 32'h1234BEEF);
        chk("st_h_mem3", {24'h0, mem[3]}, 32'hEF);
        chk("st_h_mem4", {24'h0, mem[4]}, 32'hBE);
        chk("st_h_we_cnt", we_cnt, 2);
        chk("st_h_done_cnt", lsd_cnt, 1);
        chk("st_h_lat", lat, 3);
        req(1'b1, 1'b0, SIZE_B, 32'h4, '0, 0, d, lat);
        chk("ld_b_data", d, 32'h000000BE);
        chk("ld_b_lat", lat, 3);
        chk("if_data_hold", if_data, 32'h44332211);

        // Simultaneous requests: load first, fetch after DONE + one IDLE cycle
        clr_cnt();
        k_ls = 0; k_if = 0; d_ls = '0; d_if = '0;
        ls_valid = 1'b1; ls_wr = 1'b0; ls_size = SIZE_B; ls_addr = 32'h3;
        if_valid = 1'b1; if_addr = 32'h10;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ls_done && k_ls == 0) begin k_ls = k; d_ls = ls_rdata; ls_valid = 1'b0; end
            if (if_done && k_if == 0) begin k_if = k; d_if = if_data; if_valid = 1'b0; end
            if (k_if != 0) break;
        end
        if_valid = 1'b0; ls_valid = 1'b0;
        step();
        chk("arb_ls_lat", k_ls, 3);
        chk("arb_ls_data", d_ls, 32'h000000EF);
        chk("arb_if_lat", k_if, 10);
        chk("arb_if_data", d_if, 32'h44332211);
        chk("arb_ls_cnt", lsd_cnt, 1);
        chk("arb_if_cnt", ifd_cnt, 1);

        // Clear two cycles into a fetch
        clr_cnt();
        if_valid = 1'b1; if_addr = 32'h10;
        step(); step();
        chk("clr_addr_pre", 32'(ram_addr), 32'h11);
        clear = 1'b1; if_valid = 1'b0;
        step();
        clear = 1'b0;
        chk("clr_addr_hold", 32'(ram_addr), 32'h11);
        chk("clr_no_done", ifd_cnt, 0);
        req(1'b0, 1'b0, SIZE_W, 32'h10, '0, 0, d, lat);
        chk("clr_next_lat", lat, 6);
        chk("clr_next_data", d, 32'h44332211);
        chk("clr_next_done_cnt", ifd_cnt, 1);

        // Clear during a word store has no effect
        req(1'b1, 1'b1, SIZE_W, 32'h20, 32'hCAFED00D, 2, d, lat);
        apply_store(32'h20, 4, 32'hCAFED00D);
        chk("clr_st_lat", lat, 5);
        chk("clr_st_we_cnt", we_cnt, 4);
        chk("clr_st_done_cnt", lsd_cnt, 1);
        chk_mem("clr_st_mem", 32'h20, 4);

        // Word load wrapping the top of the address space, with upper address bits set
        poke(AW'(MEM - 2), 8'($urandom)); poke(AW'(MEM - 1), 8'($urandom));
        poke(17'h0, 8'($urandom));        poke(17'h1, 8'($urandom));
        a = ($urandom() & 32'hFFFE_0000) | 32'(MEM - 2);
        e = exp_read(a, 4);
        req(1'b1, 1'b0, SIZE_W, a, '0, 0, d, lat);
        chk("wrap_data", d, e);
        chk("wrap_lat", lat, 6);

        // Reset after two store bytes
        for (int i = 0; i < 4; i++) poke(AW'(32'h200 + i), 8'h55);
        clr_cnt();
        ls_valid = 1'b1; ls_wr = 1'b1; ls_size = SIZE_W; ls_addr = 32'h200; ls_wdata = 32'hA1B2C3D4;
        step(); step();
        rst_n = 1'b0; ls_valid = 1'b0;
        step();
        chk("rstmid_we", {31'h0, ram_we}, 32'h0);
        chk("rstmid_addr", 32'(ram_addr), 32'h0);
        chk("rstmid_ls_rdata", ls_rdata, 32'h0);
        chk("rstmid_if_data", if_data, 32'h0);
        rst_n = 1'b1;
        step(); step();
        chk("rstmid_no_done", lsd_cnt, 0);
        ref_mem[AW'(32'h200)] = 8'hD4;
        ref_mem[AW'(32'h201)] = 8'hC3;
        chk_mem("rstmid_mem", 32'h200, 4);
        e = exp_read(32'h200, 4);
        req(1'b1, 1'b0, SIZE_W, 32'h200, '0, 0, d, lat);
        chk("rstmid_after_data", d, e);
        chk("rstmid_after_lat", lat, 6);

        // Randomized fetch/load/store mix over a preloaded window
        for (int i = 0; i < 68; i++) poke(AW'(32'h100 + i), 8'($urandom));
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom() & 32'hFFFE_0000) | (32'h100 + $urandom_range(0, 63));
            wd = $urandom();
            if (op == 0) begin
                e = exp_read(a, 4);
                req(1'b0, 1'b0, SIZE_W, a, '0, 0, d, lat);
                chk("rnd_fetch_data", d, e);
                chk("rnd_fetch_lat", lat, 6);
                chk("rnd_fetch_we", we_cnt, 0);
            end else if (op == 1) begin
                n = nbytes(sz);
                e = exp_read(a, n);
                req(1'b1, 1'b0, sz, a, '0, 0, d, lat);
                chk("rnd_load_data", d, e);
                chk("rnd_load_lat", lat, n + 2);
                chk("rnd_load_cnt", lsd_cnt, 1);
            end else begin
                n = nbytes(sz);
                req(1'b1, 1'b1, sz, a, wd, 0, d, lat);
                apply_store(a, n, wd);
                chk("rnd_store_lat", lat, n + 1);
                chk("rnd_store_we", we_cnt, n);
                chk_mem("rnd_store_mem", a, n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
